// File: rtl/lb_pkg.sv
// Shared widths and types for the load balancer and its region-side dispatch.
// Stats fields are {oid, load} with a saturating load so a full queue still fits the field.
package lb_pkg;
   localparam int HTTP_META_WIDTH   = 8;
   localparam int OPERATOR_ID_WIDTH = 2;
   localparam int N_REGIONS         = 4;
   localparam int QDEPTH            = 4;
   localparam int PNTR_BITS         = $clog2(QDEPTH);
   localparam int REGION_BITS       = $clog2(N_REGIONS);

   typedef logic [REGION_BITS-1:0] region_idx_t;

   typedef struct packed {
      logic [OPERATOR_ID_WIDTH-1:0] oid;
      logic [PNTR_BITS-1:0]         load;
   } stats_field_t;

   localparam int FIELD_W = $bits(stats_field_t);

   // Count reaches 2^PNTR_BITS only when full, so its top bit alone marks saturation.
   function automatic logic [PNTR_BITS-1:0] load_sat(input logic [PNTR_BITS:0] count);
      return count[PNTR_BITS] ? '1 : count[PNTR_BITS-1:0];
   endfunction
endpackage

// File: rtl/region_queue.sv
// Single-clock FIFO with occupancy count; head data is visible the cycle after the push edge.
// Pushes while full and pops while empty are ignored; push and pop together keep the count.
module region_queue #(
   parameter  int W     = 8,
   parameter  int DEPTH = 4,
   localparam int PB    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  head_data,
   output logic [PB:0]   count,
   output logic          full,
   output logic          empty
);
   localparam logic [PB:0]   FULL_CNT = (PB+1)'(DEPTH);
   localparam logic [PB:0]   CNT_ONE  = (PB+1)'(1);
   localparam logic [PB-1:0] PTR_ONE  = PB'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [PB-1:0] wr_ptr;
   logic [PB-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Head is forced to zero when empty so stale storage never leaks onto the bus.
   assign head_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/region_dispatch.sv
// Demuxes balancer beats into per-region queues, drains them per region, reports {oid, load} stats.
// Zero added latency to region head; ingress stalls only when the addressed queue is full.
module region_dispatch
   import lb_pkg::*;
(
   input  logic                                  aclk,
   input  logic                                  areset,
   input  logic                                  meta_in_tvalid,
   output logic                                  meta_in_tready,
   input  logic [HTTP_META_WIDTH-1:0]            meta_in_tdata,
   input  logic [REGION_BITS-1:0]                lb_ctrl,
   output logic [N_REGIONS-1:0]                  region_tvalid,
   input  logic [N_REGIONS-1:0]                  region_tready,
   output logic [N_REGIONS*HTTP_META_WIDTH-1:0]  region_tdata,
   input  logic                                  cfg_valid,
   output logic                                  cfg_ready,
   input  logic [REGION_BITS-1:0]                cfg_region,
   input  logic [OPERATOR_ID_WIDTH-1:0]          cfg_oid,
   output logic [N_REGIONS*FIELD_W-1:0]          region_stats_out
);
   logic [N_REGIONS-1:0] full;
   logic [N_REGIONS-1:0] empty;
   logic [N_REGIONS-1:0] push;
   logic [N_REGIONS-1:0] pop;
   logic                 cfg_fire;

   assign meta_in_tready = ~full[lb_ctrl];
   // Operator ids only change on a drained region so no queued beat is reattributed.
   assign cfg_ready      = empty[cfg_region];
   assign cfg_fire       = cfg_valid && cfg_ready;

   for (genvar i = 0; i < N_REGIONS; i++) begin : g_region
      logic [PNTR_BITS:0]           count;
      logic [OPERATOR_ID_WIDTH-1:0] oid;
      stats_field_t                 field;

      assign push[i] = meta_in_tvalid && meta_in_tready && (lb_ctrl == region_idx_t'(i));
      assign pop[i]  = region_tready[i] && !empty[i];

      region_queue #(
         .W     (HTTP_META_WIDTH),
         .DEPTH (QDEPTH)
      ) u_queue (
         .clk       (aclk),
         .rst       (areset),
         .push      (push[i]),
         .pop       (pop[i]),
         .wdata     (meta_in_tdata),
         .head_data (region_tdata[i*HTTP_META_WIDTH +: HTTP_META_WIDTH]),
         .count     (count),
         .full      (full[i]),
         .empty     (empty[i])
      );

      assign region_tvalid[i] = ~empty[i];

      always_ff @(posedge aclk or posedge areset) begin
         if (areset) begin
            oid <= '0;
         end else if (cfg_fire && (cfg_region == region_idx_t'(i))) begin
            oid <= cfg_oid;
         end
      end

      assign field.oid  = oid;
      assign field.load = load_sat(count);
      assign region_stats_out[i*FIELD_W +: FIELD_W] = field;
   end
endmodule
